// File: rtl/reverse_dabble_bcd_bin_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// The entry path drives the master side; the converter sits on the slave side.
interface reverse_dabble_bcd_bin_if #(
    parameter int N_BITS = 7
);
    logic              Iniciar;
    logic [3:0]        Dezenas;
    logic [3:0]        Unidades;
    logic [N_BITS-1:0] Binario;
    logic              Ocupado;
    logic              Pronto;
    logic              Erro;

    modport master (
        output Iniciar, Dezenas, Unidades,
        input  Binario, Ocupado, Pronto, Erro
    );

    modport slave (
        input  Iniciar, Dezenas, Unidades,
        output Binario, Ocupado, Pronto, Erro
    );
endinterface

// File: rtl/reverse_dabble_bcd_bin.sv
// Two-digit BCD to binary using reverse double-dabble: one right shift per clock,
// followed by a subtract-3 on any BCD digit that lands at 8 or above.
module reverse_dabble_bcd_bin #(
    parameter int N_BITS = 7
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    reverse_dabble_bcd_bin_if.slave   bus
);
    localparam int W  = N_BITS + 8;
    localparam int CW = $clog2(N_BITS + 1);

    typedef enum logic [1:0] {OCIOSO, DESLOCA, FIM} state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      sreg, sh, step;
    logic [CW-1:0]     cnt;
    logic [N_BITS-1:0] binario_q;
    logic              erro_q;
    logic              digits_ok, last_iter;

    function automatic logic [3:0] fix(input logic [3:0] d);
        return (d >= 4'd8) ? d - 4'd3 : d;
    endfunction

    assign digits_ok = (bus.Dezenas <= 4'd9) && (bus.Unidades <= 4'd9);
    assign last_iter = (cnt == CW'(N_BITS - 1));

    // Correction is applied to the post-shift digits within the same cycle.
    always_comb begin
        sh   = sreg >> 1;
        step = {fix(sh[W-1 -: 4]), fix(sh[W-5 -: 4]), sh[N_BITS-1:0]};
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= OCIOSO;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OCIOSO:  if (bus.Iniciar) state_nxt = digits_ok ? DESLOCA : FIM;
            DESLOCA: if (last_iter)   state_nxt = FIM;
            FIM:     state_nxt = OCIOSO;
            default: state_nxt = OCIOSO;
        endcase
    end

    // Result registers load on the edge entering FIM so they are valid alongside Pronto.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sreg      <= '0;
            cnt       <= '0;
            binario_q <= '0;
            erro_q    <= 1'b0;
        end else begin
            case (state)
                OCIOSO: begin
                    if (bus.Iniciar) begin
                        if (digits_ok) begin
                            sreg <= {bus.Dezenas, bus.Unidades, {N_BITS{1'b0}}};
                            cnt  <= '0;
                        end else begin
                            binario_q <= '0;
                            erro_q    <= 1'b1;
                        end
                    end
                end
                DESLOCA: begin
                    sreg <= step;
                    cnt  <= cnt + 1'b1;
                    if (last_iter) begin
                        binario_q <= step[N_BITS-1:0];
                        erro_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every BCD bit must have been shifted out once a valid conversion completes.
    always_ff @(posedge Clock) begin
        if (Reset_n && state == FIM && !erro_q)
            assert (sreg[W-1:N_BITS] == '0);
    end

    assign bus.Binario = binario_q;
    assign bus.Erro    = erro_q;
    assign bus.Ocupado = (state == DESLOCA);
    assign bus.Pronto  = (state == FIM);
endmodule
